// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and requester encoding for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int CW   = 16;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; on a conflict the requester that did not win last time is granted.
module rr_arbiter2
    import regfile_wb_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    req_id_e last_q;
    req_id_e last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (req_i == 2'b11) begin
            if (last_q == REQ_LSU) begin
                gnt_o  = 2'b01;
                last_d = REQ_ALU;
            end else begin
                gnt_o  = 2'b10;
                last_d = REQ_LSU;
            end
        end else if (req_i[0]) begin
            gnt_o  = 2'b01;
            last_d = REQ_ALU;
        end else if (req_i[1]) begin
            gnt_o  = 2'b10;
            last_d = REQ_LSU;
        end
    end

    // Starting at LSU makes the ALU win the first conflict after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= REQ_LSU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between ALU and LSU writebacks and tracks
// pending destination registers so decode can hold off RAW/WAW hazards.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int XLEN = regfile_wb_scheduler_pkg::XLEN,
    parameter int NREG = regfile_wb_scheduler_pkg::NREG,
    parameter int AW   = regfile_wb_scheduler_pkg::AW,
    parameter int CW   = regfile_wb_scheduler_pkg::CW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_wd,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_wd,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wd,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    output logic [NREG-1:0] pend,
    output logic [CW-1:0]   wb_count,
    output logic [CW-1:0]   conflict_count
);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0]      gnt;
    logic            accept;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_wd;

    logic            rf_we_q;
    logic [AW-1:0]   rf_rd_q;
    logic [XLEN-1:0] rf_wd_q;
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [CW-1:0]   wb_cnt_q;
    logic [CW-1:0]   cf_cnt_q;
    logic            hazard;
    logic            iss_fire;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({lsu_valid, alu_valid}),
        .gnt_o (gnt)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign lsu_ready = gnt[REQ_LSU];
    assign accept    = |gnt;
    assign sel_rd    = gnt[REQ_LSU] ? lsu_rd : alu_rd;
    assign sel_wd    = gnt[REQ_LSU] ? lsu_wd : alu_wd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wd_q <= '0;
        end else if (accept) begin
            rf_we_q <= (sel_rd != '0);
            rf_rd_q <= sel_rd;
            rf_wd_q <= sel_wd;
        end else begin
            rf_we_q <= 1'b0;
        end
    end

    assign hazard = (pend_q[iss_rs1] && iss_rs1 != '0) ||
                    (pend_q[iss_rs2] && iss_rs2 != '0) ||
                    (pend_q[iss_rd]  && iss_rd  != '0);
    assign iss_ready = !hazard;
    assign iss_fire  = iss_valid && iss_ready;

    // Clear is applied first so a same-index set overrides it.
    always_comb begin
        pend_d = pend_q;
        if (rf_we_q) begin
            pend_d[rf_rd_q] = 1'b0;
        end
        if (iss_fire && iss_rd != '0) begin
            pend_d[iss_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            wb_cnt_q <= '0;
            cf_cnt_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (rf_we_q) begin
                wb_cnt_q <= sat_inc(wb_cnt_q);
            end
            if (alu_valid && lsu_valid) begin
                cf_cnt_q <= sat_inc(cf_cnt_q);
            end
        end
    end

    assign rf_we          = rf_we_q;
    assign rf_rd          = rf_rd_q;
    assign rf_wd          = rf_wd_q;
    assign pend           = pend_q;
    assign wb_count       = wb_cnt_q;
    assign conflict_count = cf_cnt_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed testbench for regfile_wb_scheduler with hand-computed expectations.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_wd, lsu_wd;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic [31:0] pend;
    logic [15:0] wb_count, conflict_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_wd         (alu_wd),
        .lsu_valid      (lsu_valid),
        .lsu_ready      (lsu_ready),
        .lsu_rd         (lsu_rd),
        .lsu_wd         (lsu_wd),
        .rf_we          (rf_we),
        .rf_rd          (rf_rd),
        .rf_wd          (rf_wd),
        .iss_valid      (iss_valid),
        .iss_rs1        (iss_rs1),
        .iss_rs2        (iss_rs2),
        .iss_rd         (iss_rd),
        .iss_ready      (iss_ready),
        .pend           (pend),
        .wb_count       (wb_count),
        .conflict_count (conflict_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; lsu_valid = 0; alu_rd = 0; lsu_rd = 0; alu_wd = 0; lsu_wd = 0;
        iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
        tick();
        tick();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wd", rf_wd, 0);
        chk("rst_pend", pend, 0);
        chk("rst_wb_count", wb_count, 0);
        chk("rst_conflict_count", conflict_count, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_iss_ready", iss_ready, 1);
        rst = 1'b0;

        // Single ALU write
        alu_valid = 1; alu_rd = 5; alu_wd = 32'hDEADBEEF;
        #1;
        chk("t1_alu_ready", alu_ready, 1);
        chk("t1_lsu_ready", lsu_ready, 0);
        tick();
        alu_valid = 0;
        chk("t1_rf_we", rf_we, 1);
        chk("t1_rf_rd", rf_rd, 5);
        chk("t1_rf_wd", rf_wd, 32'hDEADBEEF);
        chk("t1_wb_count_pre", wb_count, 0);
        tick();
        chk("t1_rf_we_drop", rf_we, 0);
        chk("t1_rf_rd_hold", rf_rd, 5);
        chk("t1_wb_count", wb_count, 1);

        // Fresh reset so the arbiter starts from its reset priority
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("t2_wb_count_rst", wb_count, 0);

        // Four-cycle conflict: ALU, LSU, ALU, LSU
        alu_valid = 1; alu_rd = 1; alu_wd = 32'hA1;
        lsu_valid = 1; lsu_rd = 2; lsu_wd = 32'hB2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t2_alu_ready%0d", k), alu_ready, (k % 2 == 0));
            chk($sformatf("t2_lsu_ready%0d", k), lsu_ready, (k % 2 == 1));
            tick();
            chk($sformatf("t2_rf_rd%0d", k), rf_rd, (k % 2 == 0) ? 1 : 2);
            chk($sformatf("t2_rf_wd%0d", k), rf_wd, (k % 2 == 0) ? 32'hA1 : 32'hB2);
        end
        alu_valid = 0; lsu_valid = 0;
        chk("t2_conflict_count", conflict_count, 4);
        chk("t2_wb_count_mid", wb_count, 3);
        tick();
        chk("t2_wb_count", wb_count, 4);
        chk("t2_rf_we_drop", rf_we, 0);

        // LSU write to x0: accepted, not committed, still updates last grant
        lsu_valid = 1; lsu_rd = 0; lsu_wd = 32'h1234;
        #1;
        chk("t3_lsu_ready", lsu_ready, 1);
        chk("t3_alu_ready", alu_ready, 0);
        tick();
        lsu_valid = 0;
        chk("t3_rf_we", rf_we, 0);
        chk("t3_rf_wd", rf_wd, 32'h1234);
        tick();
        chk("t3_wb_count", wb_count, 4);
        alu_valid = 1; alu_rd = 3; alu_wd = 32'h33;
        lsu_valid = 1; lsu_rd = 4; lsu_wd = 32'h44;
        #1;
        chk("t3_conf_alu_ready", alu_ready, 1);
        chk("t3_conf_lsu_ready", lsu_ready, 0);
        tick();
        alu_valid = 0; lsu_valid = 0;
        chk("t3_conf_rf_we", rf_we, 1);
        chk("t3_conf_rf_rd", rf_rd, 3);
        chk("t3_conflict_count", conflict_count, 5);
        tick();
        chk("t3_wb_count_after", wb_count, 5);

        // RAW stall on x7
        iss_valid = 1; iss_rd = 7; iss_rs1 = 0; iss_rs2 = 0;
        #1;
        chk("t4_iss_ready_first", iss_ready, 1);
        tick();
        chk("t4_pend_set", pend, 32'h80);
        iss_rd = 0; iss_rs1 = 7;
        #1;
        chk("t4_raw_stall0", iss_ready, 0);
        tick();
        chk("t4_raw_stall1", iss_ready, 0);
        alu_valid = 1; alu_rd = 7; alu_wd = 32'h77;
        #1;
        chk("t4_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        chk("t4_rf_we7", rf_we, 1);
        chk("t4_rf_rd7", rf_rd, 7);
        chk("t4_pend_held", pend, 32'h80);
        chk("t4_raw_stall2", iss_ready, 0);
        tick();
        chk("t4_pend_clr", pend, 0);
        chk("t4_raw_release", iss_ready, 1);

        // WAW stall on x7
        iss_rs1 = 0; iss_rd = 7;
        tick();
        chk("t4_waw_pend", pend, 32'h80);
        chk("t4_waw_stall0", iss_ready, 0);
        lsu_valid = 1; lsu_rd = 7; lsu_wd = 32'h7777;
        #1;
        chk("t4_lsu_ready", lsu_ready, 1);
        tick();
        lsu_valid = 0;
        chk("t4_waw_stall1", iss_ready, 0);
        tick();
        chk("t4_waw_pend_clr", pend, 0);
        chk("t4_waw_release", iss_ready, 1);
        iss_valid = 0; iss_rd = 0;
        tick();

        // Issues that touch only x0 never mark anything pending
        iss_valid = 1; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t5_iss_ready%0d", k), iss_ready, 1);
            tick();
            chk($sformatf("t5_pend%0d", k), pend, 0);
        end
        iss_valid = 0;

        // Asynchronous reset with a write in flight
        iss_valid = 1; iss_rd = 7;
        alu_valid = 1; alu_rd = 9; alu_wd = 32'h99;
        tick();
        iss_valid = 0; iss_rd = 0; alu_valid = 0;
        chk("t6_rf_we_pre", rf_we, 1);
        chk("t6_pend_pre", pend, 32'h80);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rf_we_async", rf_we, 0);
        chk("t6_pend_async", pend, 0);
        chk("t6_wb_count_async", wb_count, 0);
        chk("t6_conflict_async", conflict_count, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_rf_we_after", rf_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
